mul_div_unit_divider: RTL

Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the EX stage next to the ALU. It produces `divres`, `div_ready` and the destination tag that the forwarding and writeback paths consume. It also drives a busy/stall signal that holds the front of the pipeline while a division is in flight.

---
 rtl/mul_div_unit_divider.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mul_div_unit_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow are
// resolved directly from IDLE without iterating.
module mul_div_unit_divider #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            Rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic [4:0]      rd_in,
    input  logic            kill,
    output logic [XLEN-1:0] divres,
    output logic            div_ready,
    output logic [4:0]      div_rd,
    output logic            div_busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] cnt;
    logic [XLEN:0]    rem;
    logic [XLEN:0]    dvs;
    logic [XLEN-1:0]  quo;
    logic [4:0]       rd_lat;
    logic             is_rem;
    logic             neg_q;
    logic             neg_r;

    // Two's-complement negation when n is set; identity otherwise.
    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Operand decode and special-case detection for the request in IDLE.
    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            div_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic            accept;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & dividend[XLEN-1];
    assign b_neg     = is_signed & divisor[XLEN-1];
    assign a_abs     = neg_if(dividend, a_neg);
    assign b_abs     = neg_if(divisor, b_neg);
    assign div_zero  = (divisor == '0);
    assign ovf       = is_signed & (dividend == {1'b1, {(XLEN-1){1'b0}}}) & (divisor == '1);
    assign special   = div_zero | ovf;
    // Overflow: quotient is the dividend itself (0x80000000), remainder 0.
    assign special_res = div_zero ? (op[1] ? dividend : '1)
                                  : (op[1] ? '0 : dividend);
    assign accept    = (state == IDLE) & start & ~kill;

    // One restoring step on XLEN+1 bits.
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            take;
    logic [XLEN:0]   rem_nxt;
    logic [XLEN-1:0] quo_nxt;
    logic [XLEN-1:0] final_res;
    logic            last;

    assign shifted   = {rem[XLEN-1:0], quo[XLEN-1]};
    assign diff      = shifted - dvs;
    assign take      = ~diff[XLEN];
    assign rem_nxt   = take ? diff : shifted;
    assign quo_nxt   = {quo[XLEN-2:0], take};
    assign final_res = is_rem ? neg_if(rem_nxt[XLEN-1:0], neg_r) : neg_if(quo_nxt, neg_q);
    assign last      = (cnt == CNT_W'(XLEN-1));

    assign div_ready = (state == DONE);
    assign div_busy  = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!Rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state logic: kill aborts CALC only; DONE always returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = special ? DONE : CALC;
            CALC:    if (kill) state_next = IDLE;
                     else if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, and result commit on entry to DONE.
    always_ff @(posedge clk) begin
        if (!Rst) begin
            cnt    <= '0;
            rem    <= '0;
            dvs    <= '0;
            quo    <= '0;
            rd_lat <= '0;
            is_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            divres <= '0;
            div_rd <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_rem <= op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        rd_lat <= rd_in;
                        rem    <= '0;
                        quo    <= a_abs;
                        dvs    <= {1'b0, b_abs};
                        cnt    <= '0;
                        if (special) begin
                            divres <= special_res;
                            div_rd <= rd_in;
                        end
                    end
                end
                CALC: begin
                    if (!kill) begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            divres <= final_res;
                            div_rd <= rd_lat;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
